// File: rtl/spart_rx_fifo.sv
// Receive-side message buffer after the SPART packing stage: first-word-fall-through
// FIFO of completed messages with a sticky flag for messages dropped while full.
module spart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_valid,
  input  logic [WIDTH-1:0] msg_data,
  input  logic             rd_en,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             irq
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wp_r;
  logic [AW-1:0]    rp_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             empty_s;
  logic             full_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             drop_s;

  // Flags come straight from the registered count; a pop at full frees the slot for a same-cycle write.
  always_comb begin
    empty_s  = (count_r == '0);
    full_s   = (count_r == CNT_DEPTH);
    wr_acc_s = msg_valid && (!full_s || rd_en);
    rd_acc_s = rd_en && !empty_s;
    drop_s   = msg_valid && full_s && !rd_en;
  end

  // Message storage, intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wp_r] <= msg_data;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r       <= '0;
      rp_r       <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wp_r <= wp_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rp_r <= rp_r + PTR_ONE;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Output mapping; head entry reads as zero when nothing is stored.
  always_comb begin
    if (empty_s) begin
      rd_data = '0;
    end else begin
      rd_data = mem_r[rp_r];
    end
    empty    = empty_s;
    full     = full_s;
    count    = count_r;
    overflow = overflow_r;
    irq      = !empty_s;
  end

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Bench for spart_rx_fifo: vector table with fixed expectations, queue scoreboard
// checking popped data, and hand sequences for reset and pointer wrap.
module tb_spart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg_valid = 1'b0;
  logic [23:0] msg_data = 24'h0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [23:0] rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic        irq;

  int checks = 0;
  int failures = 0;

  logic [23:0] sb[$];
  logic        ovf_m = 1'b0;

  typedef struct {
    logic        mv;
    logic [23:0] md;
    logic        re;
    logic        co;
    logic [3:0]  exp_count;
    logic        exp_full;
    logic        exp_ovf;
    logic [23:0] exp_rd;
  } vec_t;

  vec_t tv[$];

  spart_rx_fifo #(.DEPTH(8), .WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_data(msg_data),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mv, input logic [23:0] md, input logic re,
                              input logic co, input logic [3:0] c, input logic f,
                              input logic o, input logic [23:0] r);
    vec_t v;
    v.mv = mv; v.md = md; v.re = re; v.co = co;
    v.exp_count = c; v.exp_full = f; v.exp_ovf = o; v.exp_rd = r;
    return v;
  endfunction

  // One clock: drive at negedge, check fall-through head on pop, step model at posedge, compare after.
  task automatic apply(input logic mv, input logic [23:0] md, input logic re, input logic co);
    bit was_full, wr, rd, drop;
    @(negedge clk);
    msg_valid = mv; msg_data = md; rd_en = re; clr_ovf = co;
    if (re && sb.size() > 0) chk("pop_data", rd_data, sb[0]);
    @(posedge clk);
    was_full = (sb.size() == 8);
    wr   = mv && (!was_full || re);
    rd   = re && (sb.size() > 0);
    drop = mv && was_full && !re;
    if (rd) void'(sb.pop_front());
    if (wr) sb.push_back(md);
    if (drop) ovf_m = 1'b1;
    else if (co) ovf_m = 1'b0;
    #1;
    chk("model_count", count, sb.size());
    chk("model_empty", empty, sb.size() == 0);
    chk("model_irq", irq, sb.size() != 0);
    chk("model_ovf", overflow, ovf_m);
    chk("model_head", rd_data, (sb.size() == 0) ? 24'h0 : sb[0]);
  endtask

  initial begin
    // Single message, extra pop while empty, fill, overflow, clear, simultaneous at full, drain.
    tv.push_back(mk(1'b1, 24'h123456, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 24'h123456));
    tv.push_back(mk(1'b0, 24'h0,      1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 24'h0));
    tv.push_back(mk(1'b0, 24'h0,      1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 24'h0));
    for (int i = 1; i <= 8; i++)
      tv.push_back(mk(1'b1, 24'(i), 1'b0, 1'b0, 4'(i), (i == 8), 1'b0, 24'h000001));
    tv.push_back(mk(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 24'h000001));
    tv.push_back(mk(1'b1, 24'h0000CC, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1, 24'h000001));
    tv.push_back(mk(1'b0, 24'h0,      1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 24'h000001));
    tv.push_back(mk(1'b1, 24'h0000AA, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 24'h000002));
    for (int i = 3; i <= 8; i++)
      tv.push_back(mk(1'b0, 24'h0, 1'b1, 1'b0, 4'(10 - i), 1'b0, 1'b0, 24'(i)));
    tv.push_back(mk(1'b0, 24'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 24'h0000AA));
    tv.push_back(mk(1'b0, 24'h0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 24'h0));
    tv.push_back(mk(1'b1, 24'h0000BB, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 24'h0000BB));
    tv.push_back(mk(1'b0, 24'h0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 24'h0));

    #2;
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 4'd0);
    chk("rst_rd_data", rd_data, 24'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      apply(tv[i].mv, tv[i].md, tv[i].re, tv[i].co);
      chk($sformatf("vec%0d_count", i), count, tv[i].exp_count);
      chk($sformatf("vec%0d_full", i), full, tv[i].exp_full);
      chk($sformatf("vec%0d_ovf", i), overflow, tv[i].exp_ovf);
      chk($sformatf("vec%0d_rd", i), rd_data, tv[i].exp_rd);
    end

    // Reset mid-stream with three entries and overflow set.
    for (int i = 0; i < 8; i++) apply(1'b1, 24'h300 + 24'(i), 1'b0, 1'b0);
    apply(1'b1, 24'hDEAD00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply(1'b0, 24'h0, 1'b1, 1'b0);
    chk("pre_rst_count", count, 4'd3);
    chk("pre_rst_ovf", overflow, 1'b1);
    @(negedge clk);
    msg_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_count", count, 4'd0);
    chk("mid_rst_rd_data", rd_data, 24'h0);
    chk("mid_rst_irq", irq, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    sb.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 24'hA1B2C3, 1'b0, 1'b0);
    chk("post_rst_rd_data", rd_data, 24'hA1B2C3);
    chk("post_rst_count", count, 4'd1);
    apply(1'b0, 24'h0, 1'b1, 1'b0);

    // Wrap: occupancy held at 3 while 20 write/read pairs cross the pointer wrap.
    for (int i = 0; i < 3; i++) apply(1'b1, 24'h500 + 24'(i), 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) begin
      apply(1'b1, 24'h500 + 24'(i), 1'b1, 1'b0);
      chk("wrap_count", count, 4'd3);
    end
    apply(1'b0, 24'h0, 1'b1, 1'b0);
    apply(1'b0, 24'h0, 1'b1, 1'b0);
    chk("wrap_last_head", rd_data, 24'h500 + 24'd22);
    apply(1'b0, 24'h0, 1'b1, 1'b0);
    chk("wrap_drained", empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_rx_fifo.md
# spart_rx_fifo

Receive-side message buffer sitting directly downstream of the SPART packing stage. It captures each completed 24-bit message (signalled by a one-cycle word-complete strobe) into a DEPTH-entry first-word-fall-through FIFO. The processor drains messages at its own pace with a read strobe, so back-to-back messages from the board link are not lost. Messages that arrive while the FIFO is full are dropped and flagged in a sticky overflow bit.

## Interface
- DEPTH, 8, number of 24-bit entries; power of two, >= 2
- WIDTH, 24, message width in bits
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- msg_valid  input  1  word-complete strobe from packing stage; each high cycle is one write request
- msg_data  input  WIDTH  packed message, sampled when msg_valid is high
- rd_en  input  1  processor pop strobe; each high cycle pops one entry
- clr_ovf  input  1  clears the overflow flag
- rd_data  output  WIDTH  head entry (fall-through); 0 when empty
- empty  output  1  no entries stored
- full  output  1  DEPTH entries stored
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- overflow  output  1  sticky: a message was dropped
- irq  output  1  processor interrupt, level, equals ~empty

## Operation
- Storage: DEPTH x WIDTH array, write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrap modulo DEPTH; count held as separate register (not derived from pointers).
- Write accepted when msg_valid && (!full || rd_en). Accepted write stores msg_data at wp, wp <= wp+1.
- Read accepted when rd_en && !empty. Accepted read rp <= rp+1. rd_en while empty: ignored, no state change, no error flag.
- count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read or on neither.
- Full with simultaneous msg_valid and rd_en: both accepted, count stays DEPTH, no overflow.
- Empty with simultaneous msg_valid and rd_en: write accepted, read ignored; count becomes 1.
- Overflow: msg_valid && full && !rd_en drops msg_data, FIFO contents/pointers unchanged, overflow <= 1.
- clr_ovf: overflow <= 0, except set wins if a drop occurs in the same cycle.
- rd_data = mem[rp] when !empty, else 0. Memory array itself is not reset.
- msg_valid held high for N cycles is N writes (no edge detection inside the block).

## Timing
- Reset (rst_n low, asynchronous): wp=0, rp=0, count=0, overflow=0; outputs empty=1, full=0, count=0, irq=0, rd_data=0. Reset mid-operation discards all stored messages immediately; first msg_valid after release is stored at index 0.
- Write latency: msg_valid sampled at edge N; rd_data/empty/count/irq reflect it after edge N (visible in cycle N+1).
- Read: rd_data valid in the same cycle rd_en is asserted (fall-through); next entry (or 0 if now empty) appears after that edge.
- empty, full, irq derived combinationally from registered count; no extra flag latency.
- overflow rises the cycle after the dropping edge; clr_ovf takes effect after its edge.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset: assert rst_n=0 mid-stream with 3 entries stored -> empty=1, count=0, rd_data=0, irq=0, overflow=0 immediately; after release write 0xA1B2C3 -> rd_data=0xA1B2C3, count=1.
- Single message: pulse msg_valid with 0x123456 -> next cycle empty=0, irq=1, rd_data=0x123456; pulse rd_en -> empty=1, rd_data=0.
- Fill and drain (DEPTH=8): write 0x000001..0x000008 -> full=1, count=8; read 8 times -> data returned 1..8 in order, empty=1; extra rd_en leaves count=0.
- Overflow: with FIFO full, pulse msg_valid 0xFFFFFF, rd_en=0 -> overflow=1, count=8, contents unchanged; pulse clr_ovf and msg_valid together while still full -> overflow stays 1; clr_ovf alone -> overflow=0.
- Simultaneous at full: full FIFO, msg_valid=1 with 0x0000AA and rd_en=1 same cycle -> oldest popped, 0x0000AA stored at tail, count=8, overflow=0.
- Wrap-around: 20 interleaved write/read pairs with incrementing data and occupancy kept at 3 -> data order preserved across pointer wrap, count never deviates from model.
